wb_mux_seq: RTL and testbench

// - Registered successor to the combinational Wishbone multiplexer: decodes Caravel Wishbone

---
 rtl/wb_mux_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_wb_mux_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_mux_seq.sv
// wb_mux_seq: registered Wishbone decoder that routes Caravel accesses to the
// programmer, pads, debugger and entropy interfaces through a four-state FSM.
// Every target-side output is a flop. The ack is the registered ACK-state flag,
// gated with the live strobe/cycle so a master that has gone away sees no ack.
//
// Handshake: a request is valid while wb_stb_i & wb_cyc_i is high. The master
// holds the request until it sees wbs_ack_o. wbs_ack_o is a single-cycle pulse,
// and wbs_dat_o is meaningful only in that cycle. If valid drops before ACK,
// the transfer is abandoned with no ack. A strobe that has already pulsed is
// not retracted.
module wb_mux_seq #(
  parameter int LOG_CORES   = 3,
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int IO_PINS     = 16,
  parameter int DBG_ADDR_W  = 5,
  parameter int DEBUG_LAT   = 2,
  parameter int WB_WIDTH    = 32
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_we_i,
  input  logic [WB_WIDTH-1:0]    wb_adr_i,
  input  logic [WB_WIDTH-1:0]    wb_dat_i,
  output logic                   wbs_ack_o,
  output logic [WB_WIDTH-1:0]    wbs_dat_o,
  output logic                   prog_we,
  output logic [LOG_CORES-1:0]   prog_sel,
  output logic [PC_WIDTH-1:0]    prog_waddr,
  output logic [INSTR_WIDTH-1:0] prog_wdata,
  output logic                   pads_we,
  output logic                   pads_waddr,
  output logic [IO_PINS-1:0]     pads_wdata,
  output logic [LOG_CORES-1:0]   debug_sel,
  output logic [DBG_ADDR_W-1:0]  debug_addr,
  output logic                   debug_we,
  output logic [DATA_WIDTH-1:0]  debug_wdata,
  input  logic [DATA_WIDTH-1:0]  debug_rdata,
  output logic                   entropy_we,
  output logic [WB_WIDTH-1:0]    entropy_word,
  output logic [1:0]             fsm_state_o
);

  localparam int PROG_FW = LOG_CORES + PC_WIDTH;
  localparam int DBG_FW  = LOG_CORES + DBG_ADDR_W;
  localparam int CNT_W   = (DEBUG_LAT > 1) ? $clog2(DEBUG_LAT) : 1;

  localparam logic [1:0] R_PROG  = 2'b00;
  localparam logic [1:0] R_PADS  = 2'b01;
  localparam logic [1:0] R_DEBUG = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t                 state_q;
  logic [1:0]             region_q;
  logic                   we_q;
  logic                   pads_idx_q;
  logic [DBG_FW-1:0]      dbg_fld_q;
  logic [IO_PINS-1:0]     pads_dat_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IO_PINS-1:0]     shadow_q [2];
  logic                   ack_q;
  logic [WB_WIDTH-1:0]    rdat_q;
  logic                   prog_we_q, pads_we_q, debug_we_q, entropy_we_q;
  logic [LOG_CORES-1:0]   prog_sel_q, debug_sel_q;
  logic [PC_WIDTH-1:0]    prog_waddr_q;
  logic [INSTR_WIDTH-1:0] prog_wdata_q;
  logic                   pads_waddr_q;
  logic [IO_PINS-1:0]     pads_wdata_q;
  logic [DBG_ADDR_W-1:0]  debug_addr_q;
  logic [DATA_WIDTH-1:0]  debug_wdata_q;
  logic [WB_WIDTH-1:0]    entropy_word_q;

  logic valid;
  logic unused_adr;
  assign valid      = wb_stb_i & wb_cyc_i;
  // The middle address bits carry no field.
  assign unused_adr = ^wb_adr_i;

  // Control FSM. The ISSUE-cycle outputs are loaded on the IDLE->ISSUE edge,
  // so they are registered and line up with the ISSUE state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q        <= S_IDLE;
      region_q       <= '0;
      we_q           <= 1'b0;
      pads_idx_q     <= 1'b0;
      dbg_fld_q      <= '0;
      pads_dat_q     <= '0;
      cnt_q          <= '0;
      shadow_q[0]    <= '0;
      shadow_q[1]    <= '0;
      ack_q          <= 1'b0;
      rdat_q         <= '0;
      prog_we_q      <= 1'b0;
      prog_sel_q     <= '0;
      prog_waddr_q   <= '0;
      prog_wdata_q   <= '0;
      pads_we_q      <= 1'b0;
      pads_waddr_q   <= 1'b0;
      pads_wdata_q   <= '0;
      debug_sel_q    <= '0;
      debug_addr_q   <= '0;
      debug_we_q     <= 1'b0;
      debug_wdata_q  <= '0;
      entropy_we_q   <= 1'b0;
      entropy_word_q <= '0;
    end else begin
      // Every output returns to 0 unless the next state drives it.
      ack_q          <= 1'b0;
      rdat_q         <= '0;
      prog_we_q      <= 1'b0;
      prog_sel_q     <= '0;
      prog_waddr_q   <= '0;
      prog_wdata_q   <= '0;
      pads_we_q      <= 1'b0;
      pads_waddr_q   <= 1'b0;
      pads_wdata_q   <= '0;
      debug_sel_q    <= '0;
      debug_addr_q   <= '0;
      debug_we_q     <= 1'b0;
      debug_wdata_q  <= '0;
      entropy_we_q   <= 1'b0;
      entropy_word_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (valid) begin
            region_q   <= wb_adr_i[WB_WIDTH-1 -: 2];
            we_q       <= wb_we_i;
            pads_idx_q <= wb_adr_i[0];
            dbg_fld_q  <= wb_adr_i[DBG_FW-1:0];
            pads_dat_q <= wb_dat_i[IO_PINS-1:0];
            state_q    <= S_ISSUE;
            case (wb_adr_i[WB_WIDTH-1 -: 2])
              R_PROG: begin
                {prog_sel_q, prog_waddr_q} <= wb_adr_i[PROG_FW-1:0];
                prog_we_q    <= wb_we_i;
                prog_wdata_q <= wb_we_i ? wb_dat_i[INSTR_WIDTH-1:0] : '0;
              end
              R_PADS: begin
                pads_waddr_q <= wb_adr_i[0];
                pads_we_q    <= wb_we_i;
                pads_wdata_q <= wb_we_i ? wb_dat_i[IO_PINS-1:0] : '0;
              end
              R_DEBUG: begin
                {debug_sel_q, debug_addr_q} <= wb_adr_i[DBG_FW-1:0];
                debug_we_q    <= wb_we_i;
                debug_wdata_q <= wb_we_i ? wb_dat_i[DATA_WIDTH-1:0] : '0;
              end
              default: begin
                entropy_we_q   <= wb_we_i;
                entropy_word_q <= wb_we_i ? wb_dat_i : '0;
              end
            endcase
          end
        end
        S_ISSUE: begin
          // The pads strobe has fired this cycle, so the shadow follows it
          // even if the master aborts now.
          if (we_q && region_q == R_PADS)
            shadow_q[pads_idx_q] <= pads_dat_q;
          if (!valid) begin
            state_q <= S_IDLE;
          end else if (we_q) begin
            ack_q   <= 1'b1;
            state_q <= S_ACK;
          end else if (region_q == R_DEBUG) begin
            if (DEBUG_LAT == 1) begin
              rdat_q  <= WB_WIDTH'(debug_rdata);
              ack_q   <= 1'b1;
              state_q <= S_ACK;
            end else begin
              cnt_q   <= CNT_W'(DEBUG_LAT - 1);
              {debug_sel_q, debug_addr_q} <= dbg_fld_q;
              state_q <= S_WAIT;
            end
          end else begin
            if (region_q == R_PADS)
              rdat_q <= WB_WIDTH'(shadow_q[pads_idx_q]);
            ack_q   <= 1'b1;
            state_q <= S_ACK;
          end
        end
        S_WAIT: begin
          if (!valid) begin
            state_q <= S_IDLE;
          end else if (cnt_q == CNT_W'(1)) begin
            rdat_q  <= WB_WIDTH'(debug_rdata);
            ack_q   <= 1'b1;
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            {debug_sel_q, debug_addr_q} <= dbg_fld_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o    = ack_q & valid;
  assign wbs_dat_o    = rdat_q;
  assign prog_we      = prog_we_q;
  assign prog_sel     = prog_sel_q;
  assign prog_waddr   = prog_waddr_q;
  assign prog_wdata   = prog_wdata_q;
  assign pads_we      = pads_we_q;
  assign pads_waddr   = pads_waddr_q;
  assign pads_wdata   = pads_wdata_q;
  assign debug_sel    = debug_sel_q;
  assign debug_addr   = debug_addr_q;
  assign debug_we     = debug_we_q;
  assign debug_wdata  = debug_wdata_q;
  assign entropy_we   = entropy_we_q;
  assign entropy_word = entropy_word_q;
  assign fsm_state_o  = state_q;

endmodule

// File: tb/tb_wb_mux_seq.sv
// Directed bench for wb_mux_seq with DEBUG_LAT=3. Inputs change and outputs
// are sampled on the falling clock edge. Cycle 0 is the cycle in which the
// FSM, sitting in IDLE, sees the request.
module tb_wb_mux_seq;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i, wb_stb_i, wb_cyc_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        prog_we;
  logic [2:0]  prog_sel;
  logic [7:0]  prog_waddr;
  logic [31:0] prog_wdata;
  logic        pads_we, pads_waddr;
  logic [15:0] pads_wdata;
  logic [2:0]  debug_sel;
  logic [4:0]  debug_addr;
  logic        debug_we;
  logic [15:0] debug_wdata, debug_rdata;
  logic        entropy_we;
  logic [31:0] entropy_word;
  logic [1:0]  fsm_state_o;

  int vecs = 0;
  int errs = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_mux_seq #(
    .LOG_CORES(3), .PC_WIDTH(8), .INSTR_WIDTH(32), .DATA_WIDTH(16),
    .IO_PINS(16), .DBG_ADDR_W(5), .DEBUG_LAT(3), .WB_WIDTH(32)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .prog_we(prog_we), .prog_sel(prog_sel), .prog_waddr(prog_waddr),
    .prog_wdata(prog_wdata), .pads_we(pads_we), .pads_waddr(pads_waddr),
    .pads_wdata(pads_wdata), .debug_sel(debug_sel), .debug_addr(debug_addr),
    .debug_we(debug_we), .debug_wdata(debug_wdata), .debug_rdata(debug_rdata),
    .entropy_we(entropy_we), .entropy_word(entropy_word),
    .fsm_state_o(fsm_state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nb();
    @(negedge wb_clk_i);
  endtask

  task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
  endtask

  task automatic drop();
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, 32'(wbs_ack_o), 32'd0);
    chk({tag, "_dat"}, wbs_dat_o, 32'd0);
    chk({tag, "_outs"}, 32'(|{prog_we, prog_sel, prog_waddr, prog_wdata, pads_we,
        pads_waddr, pads_wdata, debug_sel, debug_addr, debug_we, debug_wdata,
        entropy_we, entropy_word}), 32'd0);
  endtask

  // Full transfer: issue in cycle 0, wait (bounded) for ack, check latency,
  // read data, and that the ack is gone one cycle later.
  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input int exp_lat, input logic [31:0] exp_dat);
    int lat;
    logic [31:0] got;
    lat = -1;
    got = '0;
    req(we, adr, dat);
    for (int i = 1; i <= 10; i++) begin
      nb();
      if (wbs_ack_o === 1'b1) begin
        lat = i;
        got = wbs_dat_o;
        break;
      end
    end
    drop();
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (!we) chk({tag, "_rdata"}, got, exp_dat);
    nb();
    chk({tag, "_pulse"}, 32'(wbs_ack_o), 32'd0);
  endtask

  initial begin
    wb_rst_i = 1'b1;
    drop();
    debug_rdata = 16'h0BAD;
    nb(); nb();
    chk_quiet("reset");
    chk("reset_state", 32'(fsm_state_o), 32'd0);
    wb_rst_i = 1'b0;
    nb();
    chk_quiet("post_reset");

    // Program write: core 5, address 0x12.
    req(1'b1, 32'h0000_0512, 32'hDEAD_BEEF);
    nb();
    chk("prog_we_c1", 32'(prog_we), 32'd1);
    chk("prog_sel", 32'(prog_sel), 32'd5);
    chk("prog_waddr", 32'(prog_waddr), 32'h12);
    chk("prog_wdata", prog_wdata, 32'hDEAD_BEEF);
    chk("prog_ack_c1", 32'(wbs_ack_o), 32'd0);
    chk("prog_other_we", 32'(|{pads_we, debug_we, entropy_we}), 32'd0);
    nb();
    chk("prog_ack_c2", 32'(wbs_ack_o), 32'd1);
    chk("prog_we_c2", 32'(prog_we), 32'd0);
    chk("prog_wdata_c2", prog_wdata, 32'd0);
    drop();
    nb();
    chk("prog_ack_c3", 32'(wbs_ack_o), 32'd0);
    chk("prog_state_c3", 32'(fsm_state_o), 32'd0);

    // Pads writes and shadow readback.
    xfer("pads_wr1", 1'b1, 32'h4000_0001, 32'h0000_A5A5, 2, 32'd0);
    xfer("pads_rd1", 1'b0, 32'h4000_0001, 32'd0, 2, 32'h0000_A5A5);
    xfer("pads_rd0", 1'b0, 32'h4000_0000, 32'd0, 2, 32'd0);
    req(1'b1, 32'h4000_0000, 32'hFFFF_1357);
    nb();
    chk("pads_we_c1", 32'(pads_we), 32'd1);
    chk("pads_waddr", 32'(pads_waddr), 32'd0);
    chk("pads_wdata", 32'(pads_wdata), 32'h1357);
    nb();
    chk("pads_wr0_ack", 32'(wbs_ack_o), 32'd1);
    chk("pads_we_c2", 32'(pads_we), 32'd0);
    drop();
    nb();
    xfer("pads_rd0b", 1'b0, 32'h4000_0000, 32'd0, 2, 32'h0000_1357);
    xfer("pads_rd1b", 1'b0, 32'h4000_0001, 32'd0, 2, 32'h0000_A5A5);

    // Debug read, core 2 register 7; data valid only from cycle 3.
    req(1'b0, 32'h8000_0047, 32'd0);
    nb();
    chk("dbg_sel_c1", 32'(debug_sel), 32'd2);
    chk("dbg_addr_c1", 32'(debug_addr), 32'd7);
    chk("dbg_we_c1", 32'(debug_we), 32'd0);
    nb();
    chk("dbg_sel_c2", 32'(debug_sel), 32'd2);
    chk("dbg_addr_c2", 32'(debug_addr), 32'd7);
    chk("dbg_ack_c2", 32'(wbs_ack_o), 32'd0);
    nb();
    chk("dbg_sel_c3", 32'(debug_sel), 32'd2);
    chk("dbg_addr_c3", 32'(debug_addr), 32'd7);
    chk("dbg_ack_c3", 32'(wbs_ack_o), 32'd0);
    debug_rdata = 16'h1234;
    nb();
    chk("dbg_ack_c4", 32'(wbs_ack_o), 32'd1);
    chk("dbg_rdata", wbs_dat_o, 32'h0000_1234);
    chk("dbg_sel_c4", 32'(debug_sel), 32'd0);
    drop();
    nb();
    chk("dbg_ack_c5", 32'(wbs_ack_o), 32'd0);
    xfer("dbg_rd2", 1'b0, 32'h8000_0047, 32'd0, 4, 32'h0000_1234);

    // Entropy write then read.
    req(1'b1, 32'hC000_0000, 32'hCAFE_F00D);
    nb();
    chk("ent_we_c1", 32'(entropy_we), 32'd1);
    chk("ent_word_c1", entropy_word, 32'hCAFE_F00D);
    chk("ent_other_we", 32'(|{prog_we, pads_we, debug_we}), 32'd0);
    nb();
    chk("ent_ack_c2", 32'(wbs_ack_o), 32'd1);
    chk("ent_we_c2", 32'(entropy_we), 32'd0);
    chk("ent_word_c2", entropy_word, 32'd0);
    drop();
    nb();
    xfer("ent_rd", 1'b0, 32'hC000_0000, 32'd0, 2, 32'd0);

    // Abort: strobe dropped in cycle 2 of a debug read.
    req(1'b0, 32'h8000_0047, 32'd0);
    nb();
    nb();
    chk("abort_state_c2", 32'(fsm_state_o), 32'd2);
    drop();
    nb();
    chk("abort_state_c3", 32'(fsm_state_o), 32'd0);
    chk_quiet("abort_c3");
    nb();
    chk("abort_ack_c4", 32'(wbs_ack_o), 32'd0);
    xfer("after_abort", 1'b0, 32'h4000_0001, 32'd0, 2, 32'h0000_A5A5);

    // Reset during WAIT clears everything, including pads shadows.
    req(1'b0, 32'h8000_0047, 32'd0);
    nb();
    nb();
    chk("rst_state_c2", 32'(fsm_state_o), 32'd2);
    wb_rst_i = 1'b1;
    nb();
    chk_quiet("rst_c3");
    chk("rst_state_c3", 32'(fsm_state_o), 32'd0);
    wb_rst_i = 1'b0;
    drop();
    nb();
    xfer("rst_shadow1", 1'b0, 32'h4000_0001, 32'd0, 2, 32'd0);
    xfer("rst_shadow0", 1'b0, 32'h4000_0000, 32'd0, 2, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
